// File: rtl/z80_bus_pkg.sv
// Shared Z80 I/O bus types and address-decode helper.
package z80_bus_pkg;

  // Bus-cycle sequencer states for the I/O port bank.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StAccess = 2'd2,
    StDone   = 2'd3
  } io_state_t;

  // True when addr falls in [base, base+n); with decode16=0 only the low byte is compared,
  // so the window wraps modulo 256.
  function automatic logic io_hit(input logic [15:0] addr, input logic [15:0] base,
                                  input int unsigned n, input logic decode16);
    logic [15:0] off;
    off = addr - base;
    if (!decode16) begin
      off[15:8] = 8'h00;
    end
    return (32'(off) < n);
  endfunction

endpackage

// File: rtl/z80_wait_gen.sv
// Loadable down-counter that holds Z80 WAIT low for a programmed number of clocks.
module z80_wait_gen (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_abort,
  output logic       o_wait_n,
  output logic       o_done
);

  logic       active_q;
  logic [3:0] cnt_q;
  logic       wait_n_q;

  // Count down while active; WAIT is released on the same edge the count expires.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      active_q <= 1'b0;
      cnt_q    <= 4'd0;
      wait_n_q <= 1'b1;
    end else if (i_abort) begin
      active_q <= 1'b0;
      wait_n_q <= 1'b1;
    end else if (i_load) begin
      active_q <= 1'b1;
      cnt_q    <= i_load_val;
      wait_n_q <= 1'b0;
    end else if (active_q) begin
      if (cnt_q == 4'd0) begin
        active_q <= 1'b0;
        wait_n_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Done flags the last wait cycle so the sequencer can leave WAIT on the release edge.
  always_comb begin
    o_done = active_q && (cnt_q == 4'd0);
  end

  assign o_wait_n = wait_n_q;

endmodule

// File: rtl/z80_io_port_bank.sv
// Bank of 8-bit Z80 I/O port registers with window decode, wait states and write strobes.
module z80_io_port_bank
  import z80_bus_pkg::*;
#(
  parameter int unsigned          NUM_PORTS   = 4,
  parameter logic [15:0]          BASE_ADDR   = 16'h00E0,
  parameter bit                   DECODE_16   = 1'b0,
  parameter logic [NUM_PORTS-1:0] INPUT_MASK  = '0,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [7:0]           RESET_VAL   = 8'h00
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_iorq_n,
  input  logic                   i_m1_n,
  input  logic                   i_rd_n,
  input  logic                   i_wr_n,
  input  logic [15:0]            i_addr,
  input  logic [7:0]             i_din,
  output logic [7:0]             o_dout,
  output logic                   o_dout_en,
  output logic                   o_wait_n,
  input  logic [NUM_PORTS*8-1:0] i_port_in,
  output logic [NUM_PORTS*8-1:0] o_port_out,
  output logic [NUM_PORTS-1:0]   o_wr_stb
);

  localparam int unsigned IdxW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [3:0]  WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  io_state_t                   state_q, state_d;
  logic [IdxW-1:0]             idx_q, bus_idx, acc_idx;
  logic                        rd_q, acc_rd;
  logic                        hit, commit;
  logic                        wait_load, wait_abort, wait_done;
  logic [NUM_PORTS-1:0][7:0]   port_q;
  logic [7:0]                  rd_data;
  logic [7:0]                  dout_q;
  logic                        dout_en_q;
  logic [NUM_PORTS-1:0]        stb_q;

  // Interrupt acknowledge (M1 low with IORQ) is never decoded.
  always_comb begin
    hit     = !i_iorq_n && i_m1_n && (!i_rd_n || !i_wr_n) &&
              io_hit(i_addr, BASE_ADDR, NUM_PORTS, DECODE_16);
    bus_idx = i_addr[IdxW-1:0] - BASE_ADDR[IdxW-1:0];
    // With no wait states the access commits on the hit edge, before idx/dir are latched.
    acc_idx = (state_q == StIdle) ? bus_idx : idx_q;
    acc_rd  = (state_q == StIdle) ? !i_rd_n : rd_q;
  end

  // Next-state logic; commit marks the edge that enters ACCESS so read latency is 1+WAIT_STATES.
  always_comb begin
    state_d    = state_q;
    wait_load  = 1'b0;
    wait_abort = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          if (WAIT_STATES > 0) begin
            state_d   = StWait;
            wait_load = 1'b1;
          end else begin
            state_d = StAccess;
            commit  = 1'b1;
          end
        end
      end
      StWait: begin
        if (i_iorq_n) begin
          state_d    = StIdle;
          wait_abort = 1'b1;
        end else if (wait_done) begin
          state_d = StAccess;
          commit  = 1'b1;
        end
      end
      StAccess: state_d = StDone;
      StDone:   if (i_iorq_n) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Read mux: input ports return the external value, output ports their register.
  always_comb begin
    rd_data = 8'h00;
    for (int k = 0; k < int'(NUM_PORTS); k++) begin
      if (acc_idx == IdxW'(k)) begin
        rd_data = INPUT_MASK[k] ? i_port_in[k*8 +: 8] : port_q[k];
      end
    end
  end

  // Sequencer state and the port/direction captured at the hit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && hit) begin
        idx_q <= bus_idx;
        rd_q  <= !i_rd_n;
      end
    end
  end

  // Port registers and single-cycle strobes; writes to input ports are dropped.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      port_q <= {NUM_PORTS{RESET_VAL}};
      stb_q  <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_PORTS); k++) begin
        stb_q[k] <= 1'b0;
        if (commit && !acc_rd && acc_idx == IdxW'(k) && !INPUT_MASK[k]) begin
          port_q[k] <= i_din;
          stb_q[k]  <= 1'b1;
        end
      end
    end
  end

  // Read data is held until IORQ rises in DONE.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dout_q    <= 8'h00;
      dout_en_q <= 1'b0;
    end else if (commit && acc_rd) begin
      dout_q    <= rd_data;
      dout_en_q <= 1'b1;
    end else if (state_q == StDone && i_iorq_n) begin
      dout_en_q <= 1'b0;
    end
  end

  z80_wait_gen u_wait_gen (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (wait_load),
    .i_load_val (WaitLoad),
    .i_abort    (wait_abort),
    .o_wait_n   (o_wait_n),
    .o_done     (wait_done)
  );

  assign o_dout     = dout_q;
  assign o_dout_en  = dout_en_q;
  assign o_port_out = port_q;
  assign o_wr_stb   = stb_q;

endmodule

// File: tb/tb_z80_io_port_bank.sv
// Directed bench: four bank instances share one Z80 I/O bus, each with its own expectations.
module tb_z80_io_port_bank;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        iorq_n = 1'b1, m1_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic [31:0] port_in = 32'h0000_0000;

  logic [7:0]  a_dout, w_dout, d_dout, f_dout;
  logic        a_en, w_en, d_en, f_en;
  logic        a_wait, w_wait, d_wait, f_wait;
  logic [31:0] a_out, w_out, d_out, f_out;
  logic [3:0]  a_stb, w_stb, d_stb, f_stb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Base E0, port 2 input, no wait states.
  z80_io_port_bank #(.NUM_PORTS(4), .BASE_ADDR(16'h00E0), .DECODE_16(1'b0),
    .INPUT_MASK(4'b0100), .WAIT_STATES(0), .RESET_VAL(8'h00)) u_a (
    .i_clk(clk), .i_reset_n(reset_n), .i_iorq_n(iorq_n), .i_m1_n(m1_n), .i_rd_n(rd_n),
    .i_wr_n(wr_n), .i_addr(addr), .i_din(din), .o_dout(a_dout), .o_dout_en(a_en),
    .o_wait_n(a_wait), .i_port_in(port_in), .o_port_out(a_out), .o_wr_stb(a_stb));

  // Same window, three wait states, non-zero reset value.
  z80_io_port_bank #(.NUM_PORTS(4), .BASE_ADDR(16'h00E0), .DECODE_16(1'b0),
    .INPUT_MASK(4'b0100), .WAIT_STATES(3), .RESET_VAL(8'hA5)) u_w (
    .i_clk(clk), .i_reset_n(reset_n), .i_iorq_n(iorq_n), .i_m1_n(m1_n), .i_rd_n(rd_n),
    .i_wr_n(wr_n), .i_addr(addr), .i_din(din), .o_dout(w_dout), .o_dout_en(w_en),
    .o_wait_n(w_wait), .i_port_in(port_in), .o_port_out(w_out), .o_wr_stb(w_stb));

  // Full 16-bit decode at 12E0.
  z80_io_port_bank #(.NUM_PORTS(4), .BASE_ADDR(16'h12E0), .DECODE_16(1'b1),
    .INPUT_MASK(4'b0000), .WAIT_STATES(0), .RESET_VAL(8'h00)) u_d (
    .i_clk(clk), .i_reset_n(reset_n), .i_iorq_n(iorq_n), .i_m1_n(m1_n), .i_rd_n(rd_n),
    .i_wr_n(wr_n), .i_addr(addr), .i_din(din), .o_dout(d_dout), .o_dout_en(d_en),
    .o_wait_n(d_wait), .i_port_in(port_in), .o_port_out(d_out), .o_wr_stb(d_stb));

  // Window FE..01, wrapping through 00.
  z80_io_port_bank #(.NUM_PORTS(4), .BASE_ADDR(16'h00FE), .DECODE_16(1'b0),
    .INPUT_MASK(4'b0000), .WAIT_STATES(0), .RESET_VAL(8'h00)) u_f (
    .i_clk(clk), .i_reset_n(reset_n), .i_iorq_n(iorq_n), .i_m1_n(m1_n), .i_rd_n(rd_n),
    .i_wr_n(wr_n), .i_addr(addr), .i_din(din), .o_dout(f_dout), .o_dout_en(f_en),
    .o_wait_n(f_wait), .i_port_in(port_in), .o_port_out(f_out), .o_wr_stb(f_stb));

  task automatic bus_begin(input logic [15:0] a, input bit is_rd, input logic [7:0] d);
    @(negedge clk);
    addr   = a;
    din    = d;
    iorq_n = 1'b0;
    rd_n   = !is_rd;
    wr_n   = is_rd;
  endtask

  task automatic bus_end();
    @(negedge clk);
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    m1_n   = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (a_dout !== 8'h00) begin errors++;
      $display("FAIL reset_dout: got %h expected 00", a_dout); end
    checks++; if (a_en !== 1'b0 || w_en !== 1'b0) begin errors++;
      $display("FAIL reset_dout_en: got %b%b expected 00", a_en, w_en); end
    checks++; if (w_wait !== 1'b1) begin errors++;
      $display("FAIL reset_wait_n: got %b expected 1", w_wait); end
    checks++; if (a_stb !== 4'h0) begin errors++;
      $display("FAIL reset_stb: got %h expected 0", a_stb); end
    checks++; if (w_out !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL reset_val: got %h expected a5a5a5a5", w_out); end
    reset_n = 1'b1;
  endtask

  task automatic test_read_input();
    int first_a = -1, first_w = -1, wlow = 0, stray = 0;
    port_in = 32'h00C1_0000;
    bus_begin(16'h00E2, 1'b1, 8'h00);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (a_en && first_a < 0) first_a = i;
      if (w_en && first_w < 0) first_w = i;
      if (!w_wait) wlow++;
      if (d_en || f_en) stray++;
    end
    checks++; if (first_a !== 1) begin errors++;
      $display("FAIL read_latency_ws0: got %0d expected 1", first_a); end
    checks++; if (first_w !== 4) begin errors++;
      $display("FAIL read_latency_ws3: got %0d expected 4", first_w); end
    checks++; if (wlow !== 3) begin errors++;
      $display("FAIL wait_low_clocks: got %0d expected 3", wlow); end
    checks++; if (a_dout !== 8'hC1 || w_dout !== 8'hC1) begin errors++;
      $display("FAIL read_input_data: got %h/%h expected c1/c1", a_dout, w_dout); end
    checks++; if (stray !== 0) begin errors++;
      $display("FAIL read_nonhit_quiet: got %0d expected 0", stray); end
    bus_end();
    checks++; if (a_en !== 1'b0 || w_en !== 1'b0) begin errors++;
      $display("FAIL read_en_clear: got %b%b expected 00", a_en, w_en); end
  endtask

  task automatic test_write_readback();
    int a_good = 0, a_bad = 0, w_good = 0, w_bad = 0;
    bus_begin(16'h00E1, 1'b0, 8'h5A);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (a_stb == 4'b0010) a_good++; else if (a_stb != 4'b0000) a_bad++;
      if (w_stb == 4'b0010) w_good++; else if (w_stb != 4'b0000) w_bad++;
    end
    checks++; if (a_good !== 1 || a_bad !== 0) begin errors++;
      $display("FAIL write_stb_ws0: got %0d/%0d expected 1/0", a_good, a_bad); end
    checks++; if (w_good !== 1 || w_bad !== 0) begin errors++;
      $display("FAIL write_stb_ws3: got %0d/%0d expected 1/0", w_good, w_bad); end
    checks++; if (a_out[15:8] !== 8'h5A || w_out[15:8] !== 8'h5A) begin errors++;
      $display("FAIL write_reg: got %h/%h expected 5a/5a", a_out[15:8], w_out[15:8]); end
    checks++; if (w_out[7:0] !== 8'hA5) begin errors++;
      $display("FAIL write_neighbour: got %h expected a5", w_out[7:0]); end
    bus_end();
    bus_begin(16'h00E1, 1'b1, 8'h00);
    repeat (6) @(negedge clk);
    checks++; if (a_en !== 1'b1 || a_dout !== 8'h5A) begin errors++;
      $display("FAIL readback_ws0: got %b/%h expected 1/5a", a_en, a_dout); end
    checks++; if (w_en !== 1'b1 || w_dout !== 8'h5A) begin errors++;
      $display("FAIL readback_ws3: got %b/%h expected 1/5a", w_en, w_dout); end
    bus_end();
  endtask

  task automatic test_input_write();
    int nstb = 0;
    bus_begin(16'h00E2, 1'b0, 8'h77);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (a_stb != 4'h0 || w_stb != 4'h0) nstb++;
    end
    checks++; if (nstb !== 0) begin errors++;
      $display("FAIL input_write_stb: got %0d expected 0", nstb); end
    checks++; if (a_out[23:16] !== 8'h00 || w_out[23:16] !== 8'hA5) begin errors++;
      $display("FAIL input_write_reg: got %h/%h expected 00/a5", a_out[23:16], w_out[23:16]); end
    bus_end();
  endtask

  task automatic test_intack();
    int resp = 0;
    @(negedge clk);
    addr = 16'h00E0; m1_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (a_en || !w_wait || w_en || a_stb != 4'h0) resp++;
    end
    checks++; if (resp !== 0) begin errors++;
      $display("FAIL intack_ignored: got %0d expected 0", resp); end
    bus_end();
  endtask

  task automatic test_decode16();
    int good = 0, other = 0;
    bus_begin(16'h12E3, 1'b0, 8'h3C);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (d_stb == 4'b1000) good++; else if (d_stb != 4'h0) other++;
    end
    bus_end();
    checks++; if (good !== 1 || other !== 0 || d_out[31:24] !== 8'h3C) begin errors++;
      $display("FAIL dec16_write: got %0d/%0d/%h expected 1/0/3c", good, other, d_out[31:24]); end
    good = 0;
    bus_begin(16'h00E3, 1'b0, 8'h99);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (d_stb != 4'h0) good++;
    end
    bus_end();
    checks++; if (good !== 0 || d_out[31:24] !== 8'h3C) begin errors++;
      $display("FAIL dec16_alias_write: got %0d/%h expected 0/3c", good, d_out[31:24]); end
    bus_begin(16'h12E3, 1'b1, 8'h00);
    repeat (3) @(negedge clk);
    checks++; if (d_en !== 1'b1 || d_dout !== 8'h3C) begin errors++;
      $display("FAIL dec16_read: got %b/%h expected 1/3c", d_en, d_dout); end
    bus_end();
    good = 0;
    bus_begin(16'h00E0, 1'b1, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (d_en) good++;
    end
    checks++; if (good !== 0) begin errors++;
      $display("FAIL dec16_miss: got %0d expected 0", good); end
    bus_end();
  endtask

  task automatic test_wrap();
    int resp = 0;
    bus_begin(16'h0001, 1'b0, 8'h11);
    repeat (3) @(negedge clk);
    bus_end();
    bus_begin(16'h00FF, 1'b0, 8'h22);
    repeat (3) @(negedge clk);
    bus_end();
    checks++; if (f_out !== 32'h1100_2200) begin errors++;
      $display("FAIL wrap_regs: got %h expected 11002200", f_out); end
    bus_begin(16'h0002, 1'b1, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (f_en) resp++;
    end
    checks++; if (resp !== 0) begin errors++;
      $display("FAIL wrap_miss: got %0d expected 0", resp); end
    bus_end();
  endtask

  task automatic test_abort();
    int nstb = 0;
    bus_begin(16'h00E0, 1'b0, 8'hF0);
    repeat (2) @(negedge clk);
    checks++; if (w_wait !== 1'b0) begin errors++;
      $display("FAIL abort_in_wait: got %b expected 0", w_wait); end
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    checks++; if (w_wait !== 1'b1) begin errors++;
      $display("FAIL abort_release: got %b expected 1", w_wait); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (w_stb != 4'h0) nstb++;
    end
    checks++; if (nstb !== 0 || w_out[7:0] !== 8'hA5) begin errors++;
      $display("FAIL abort_no_commit: got %0d/%h expected 0/a5", nstb, w_out[7:0]); end
  endtask

  task automatic test_reset_wait();
    bus_begin(16'h00E3, 1'b0, 8'hEE);
    repeat (2) @(negedge clk);
    checks++; if (w_wait !== 1'b0) begin errors++;
      $display("FAIL rst_pre_wait: got %b expected 0", w_wait); end
    reset_n = 1'b0;
    #1;
    checks++; if (w_wait !== 1'b1 || w_en !== 1'b0 || w_stb !== 4'h0) begin errors++;
      $display("FAIL rst_immediate: got %b/%b/%h expected 1/0/0", w_wait, w_en, w_stb); end
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (w_out !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL rst_regs: got %h expected a5a5a5a5", w_out); end
    checks++; if (a_out !== 32'h0000_0000) begin errors++;
      $display("FAIL rst_regs_a: got %h expected 00000000", a_out); end
  endtask

  initial begin
    test_reset();
    test_read_input();
    test_write_readback();
    test_input_write();
    test_intack();
    test_decode16();
    test_wrap();
    test_abort();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/z80_io_port_bank.md
# z80_io_port_bank

Parametrised bank of 8-bit I/O port registers that decodes the Z80 I/O bus (`iorq_n`, `rd_n`, `wr_n`, `m1_n`, `A`) and serves `IN`/`OUT` cycles. It extends the bench's flat 256-entry I/O array into synthesizable RTL with:
- a configurable port count and base address,
- optional full 16-bit decode,
- per-port input or output mode,
- programmable wait-state insertion,
- single-shot write strobes.

It sits beside the tv80s core and drives the core's `di` mux when `o_dout_en` is high.

## Interface
- `NUM_PORTS`, 4 — number of ports; power of two, 1..128.
- `BASE_ADDR`, 16'h00E0 — address of port 0; aligned to `NUM_PORTS`.
- `DECODE_16`, 0 — 0: decode `A[7:0]` only; 1: decode all of `A[15:0]`.
- `INPUT_MASK`, 0 — bit k=1 makes port k an input port: reads return `i_port_in[k]`, writes are ignored.
- `WAIT_STATES`, 0 — extra cycles `o_wait_n` is held low per access, 0..15.
- `RESET_VAL`, 8'h00 — reset value of every output register.

Ports:
- `i_clk` in 1 — clock, the CPU clock.
- `i_reset_n` in 1 — asynchronous active-low reset.
- `i_iorq_n` in 1 — Z80 IORQ.
- `i_m1_n` in 1 — Z80 M1; `M1=0` with `IORQ=0` is an interrupt acknowledge and is never decoded.
- `i_rd_n` in 1 — Z80 RD.
- `i_wr_n` in 1 — Z80 WR.
- `i_addr` in 16 — Z80 address bus.
- `i_din` in 8 — CPU data out.
- `o_dout` out 8 — read data.
- `o_dout_en` out 1 — read data valid; selects the bank onto the CPU `di` bus.
- `o_wait_n` out 1 — Z80 WAIT, active low.
- `i_port_in` in NUM_PORTS*8 — external values for input ports.
- `o_port_out` out NUM_PORTS*8 — register contents.
- `o_wr_stb` out NUM_PORTS — one-cycle pulse per committed write.

## Operation
- **Hit:** `iorq_n=0`, `m1_n=1`, `(rd_n=0 or wr_n=0)`, and the address lies in `[BASE_ADDR, BASE_ADDR+NUM_PORTS)`. The compare uses the low 8 bits or all 16 bits according to `DECODE_16`. The port index is `addr - BASE_ADDR`, truncated to `clog2(NUM_PORTS)` bits.
- **FSM states:** `IDLE`, `WAIT`, `ACCESS`, `DONE`.
- **IDLE:**
  - On a hit with `WAIT_STATES>0`: go to `WAIT`, load the wait counter with `WAIT_STATES-1`, and drive `o_wait_n` low.
  - On a hit with `WAIT_STATES==0`: go to `ACCESS`.
  - The port index and the read/write direction are latched at the hit.
- **WAIT:** decrement the counter; at 0, release `o_wait_n` and go to `ACCESS`.
- **ACCESS (one cycle):**
  - Write to an output port: commit `i_din` to the register and pulse `o_wr_stb[k]`.
  - Write to an input port: dropped, no strobe.
  - Read: `o_dout` is loaded from the register, or from `i_port_in` for an input port, and `o_dout_en` goes high.
  - Next state is `DONE`.
- **DONE:** hold `o_dout`/`o_dout_en` while `iorq_n=0`. When `iorq_n=1`, clear `o_dout_en` and return to `IDLE`. Each bus cycle therefore commits exactly once, however long IORQ stays low.
- **Abort:** if `iorq_n` rises in `WAIT`, return to `IDLE` with no commit and release `o_wait_n` immediately.
- **Reset:**
  - All registers take `RESET_VAL`.
  - FSM goes to `IDLE`.
  - `o_dout`=00, `o_dout_en`=0, `o_wait_n`=1, `o_wr_stb`=0.
  - Reset asserted mid-access aborts the access and commits nothing.
- **Non-hit:** addresses outside the window are ignored; `o_dout_en` stays 0.
- **Wrap:** with `DECODE_16=0`, the window wraps modulo 256; e.g. `BASE_ADDR`=FE with 4 ports covers FE, FF, 00, 01.

## Timing
- Read latency, first hit cycle to `o_dout_en`=1: `1+WAIT_STATES` clocks. The tv80 samples data at the T3 falling edge, so this must hold for `WAIT_STATES=0` with the `IN A,(n)` timing.
- `o_wait_n` is low for exactly `WAIT_STATES` clocks, starting on the clock after the hit edge.
- `o_wr_stb` is high for exactly one clock, coincident with the register update.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- A shared package `z80_bus_pkg` holds:
  - the FSM state enum `io_state_t`;
  - the function `io_hit(addr, base, n, decode16)`.
- One sub-module, `z80_wait_gen`: a loadable down-counter that drives `o_wait_n` and a `done` flag.
- The register array is inline in the top module.

## Test plan
- **Read input port:** `BASE_ADDR`=E0, `INPUT_MASK`=4, `i_port_in[2]`=C1. An `IN A,(E2h)` cycle gives `o_dout`=C1 with `o_dout_en`=1, and the core's A ends as C1.
- **Write then read back:** `OUT (E1h),A` with A=5A gives `o_port_out[1]`=5A and a single `o_wr_stb[1]` pulse. A following `IN` from E1 returns 5A.
- **Wait states:** with `WAIT_STATES`=3, `o_wait_n` is low for exactly 3 clocks and the `IN` instruction stretches by 3 clocks.
- **Decode and write rules:**
  - With `DECODE_16`=1, `BASE_ADDR`=12E0: address 00E0 gives no response; 12E0 hits.
  - A write to an input port changes nothing and gives no strobe.
  - An IORQ with M1 low (interrupt acknowledge) gives no response.
- **Reset and long IORQ:**
  - Pulling `i_reset_n` low during `WAIT`: `o_wait_n`=1 and `o_dout_en`=0 immediately, and the register keeps `RESET_VAL`.
  - IORQ held low for 6 clocks produces exactly 1 strobe.
